// File: rtl/prog_mealy_seq_detector_if.sv
// Serial-input and configuration bundle for prog_mealy_seq_detector.
// master = bit source / configuring agent, slave = detector.
interface prog_mealy_seq_detector_if #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned CNT_W   = 8
);
    logic               in;
    logic               in_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               dec;
    logic               configured;
    logic [CNT_W-1:0]   match_cnt;

    modport master (
        output in, in_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        input  dec, configured, match_cnt
    );

    modport slave (
        input  in, in_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        output dec, configured, match_cnt
    );
endinterface

// File: rtl/prog_mealy_seq_detector.sv
// Runtime-programmable Mealy sequence detector (pattern, length, overlap loaded at run time).
// Define SEQ_DET_CNT_EN to build the saturating match counter; otherwise match_cnt is tied to 0.
module prog_mealy_seq_detector #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    prog_mealy_seq_detector_if.slave bus
);
    localparam int unsigned HW = (MAX_LEN > 1) ? MAX_LEN - 1 : 1;
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN - 1);

    typedef enum logic {
        UNCFG = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t             state, state_next;
    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   len;
    logic               ovl;
    logic [HW-1:0]      hist;
    logic [LEN_W-1:0]   fill;

    logic               accept;
    logic               take_bit;
    logic               match_now;
    logic [LEN_W-1:0]   len_clamped;
    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] mask;

    // Newest bit sits at LSB; only the low len bits of the window are compared.
    generate
        if (MAX_LEN > 1) begin : g_window
            assign window = {hist[MAX_LEN-2:0], bus.in};
        end else begin : g_window_1
            assign window = bus.in;
        end
    endgenerate

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < 32'(len));
        end
    end

    assign len_clamped = (bus.cfg_len > LEN_MAX) ? LEN_MAX : bus.cfg_len;

    always_comb begin
        state_next = state;
        accept     = bus.cfg_load && (bus.cfg_len != '0);
        take_bit   = 1'b0;
        match_now  = 1'b0;
        case (state)
            UNCFG: begin
                if (accept) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                take_bit  = bus.in_valid && !bus.cfg_load;
                match_now = take_bit
                         && (fill >= (len - LEN_W'(1)))
                         && (((window ^ pat) & mask) == '0);
            end
            default: state_next = UNCFG;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= UNCFG;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat  <= '0;
            len  <= '0;
            ovl  <= 1'b0;
            hist <= '0;
            fill <= '0;
        end else if (accept) begin
            pat  <= bus.cfg_pattern;
            len  <= len_clamped;
            ovl  <= bus.cfg_overlap;
            hist <= '0;
            fill <= '0;
        end else if (take_bit) begin
            hist <= window[HW-1:0];
            // Non-overlapping mode discards the matched window by emptying the fill count.
            if (match_now && !ovl) begin
                fill <= '0;
            end else if (fill != FILL_MAX) begin
                fill <= fill + LEN_W'(1);
            end
        end
    end

`ifdef SEQ_DET_CNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if (match_now && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bus.match_cnt = cnt;
`else
    assign bus.match_cnt = '0;
`endif

    assign bus.dec        = match_now;
    assign bus.configured = (state == RUN);

endmodule

// File: tb/tb_prog_mealy_seq_detector.sv
// Directed bench for prog_mealy_seq_detector: default instance plus a CNT_W=2 instance.
module tb_prog_mealy_seq_detector;
`ifdef SEQ_DET_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    prog_mealy_seq_detector_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) bus1 ();
    prog_mealy_seq_detector_if #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) bus2 ();

    prog_mealy_seq_detector #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    prog_mealy_seq_detector #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled 3 ns later.
    task automatic drive1(input logic b, input logic v, input logic ld,
                          input logic [7:0] p, input logic [3:0] l, input logic o);
        @(posedge clk);
        #1;
        bus1.in          = b;
        bus1.in_valid    = v;
        bus1.cfg_load    = ld;
        bus1.cfg_pattern = p;
        bus1.cfg_len     = l;
        bus1.cfg_overlap = o;
        #3;
    endtask

    task automatic bit1(input logic b, input logic v, input logic exp, input string tag);
        drive1(b, v, 1'b0, 8'h00, 4'd0, 1'b0);
        check(tag, 32'(bus1.dec), 32'(exp));
    endtask

    task automatic load1(input logic [7:0] p, input logic [3:0] l, input logic o);
        drive1(1'b0, 1'b0, 1'b1, p, l, o);
        check("load_dec", 32'(bus1.dec), 32'd0);
    endtask

    task automatic idle_cnt1(input int exp, input string tag);
        drive1(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
        check(tag, 32'(bus1.match_cnt), CNT_EN ? 32'(exp) : 32'd0);
    endtask

    // bits/exp are listed first-bit-at-MSB over n positions.
    task automatic stream1(input logic [15:0] bits, input int n, input logic [15:0] exp,
                           input bit gaps, input string tag);
        logic [15:0] bv;
        logic [15:0] ev;
        bv = bits;
        ev = exp;
        for (int i = 0; i < n; i++) begin
            bit1(bv[n-1-i], 1'b1, ev[n-1-i], tag);
            if (gaps) begin
                bit1(~bv[n-1-i], 1'b0, 1'b0, {tag, "_gap"});
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus1.in = 1'b0; bus1.in_valid = 1'b0; bus1.cfg_load = 1'b0;
        bus1.cfg_pattern = '0; bus1.cfg_len = '0; bus1.cfg_overlap = 1'b0;
        bus2.in = 1'b0; bus2.in_valid = 1'b0; bus2.cfg_load = 1'b0;
        bus2.cfg_pattern = '0; bus2.cfg_len = '0; bus2.cfg_overlap = 1'b0;
        #2;
        check("rst_dec", 32'(bus1.dec), 32'd0);
        check("rst_configured", 32'(bus1.configured), 32'd0);
        check("rst_cnt", 32'(bus1.match_cnt), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // T4: unconfigured, rejected zero-length load, then len=1
        bit1(1'b1, 1'b1, 1'b0, "uncfg_dec_a");
        bit1(1'b0, 1'b1, 1'b0, "uncfg_dec_b");
        bit1(1'b1, 1'b0, 1'b0, "uncfg_dec_c");
        check("uncfg_configured", 32'(bus1.configured), 32'd0);
        load1(8'h01, 4'd0, 1'b0);
        bit1(1'b1, 1'b1, 1'b0, "len0_dec");
        check("len0_configured", 32'(bus1.configured), 32'd0);
        load1(8'h01, 4'd1, 1'b0);
        bit1(1'b1, 1'b1, 1'b1, "len1_dec_a");
        check("len1_configured", 32'(bus1.configured), 32'd1);
        bit1(1'b0, 1'b1, 1'b0, "len1_dec_b");
        bit1(1'b1, 1'b0, 1'b0, "len1_dec_gap");
        bit1(1'b1, 1'b1, 1'b1, "len1_dec_c");
        drive1(1'b1, 1'b1, 1'b1, 8'h01, 4'd1, 1'b0);
        check("load_prio_dec", 32'(bus1.dec), 32'd0);
        check("len1_cnt", 32'(bus1.match_cnt), CNT_EN ? 32'd2 : 32'd0);
        idle_cnt1(0, "load_clears_cnt");

        // T1 / T2 / T3
        load1(8'h0D, 4'd4, 1'b1);
        stream1(16'b1101101, 7, 16'b0001001, 1'b0, "t1_dec");
        idle_cnt1(2, "t1_cnt");
        load1(8'h0D, 4'd4, 1'b0);
        stream1(16'b1101101, 7, 16'b0001000, 1'b0, "t2_dec");
        idle_cnt1(1, "t2_cnt");
        load1(8'h0D, 4'd4, 1'b1);
        stream1(16'b1101101, 7, 16'b0001001, 1'b1, "t3_dec");
        idle_cnt1(2, "t3_cnt");

        // T5: full length, then over-length clamped
        load1(8'hA5, 4'd8, 1'b1);
        stream1(16'hA5A5, 16, 16'h0101, 1'b0, "t5_dec");
        idle_cnt1(2, "t5_cnt");
        load1(8'hA5, 4'd12, 1'b1);
        stream1(16'hA5A5, 16, 16'h0101, 1'b0, "t5_clamp_dec");
        idle_cnt1(2, "t5_clamp_cnt");

        // T6: 2-bit saturating counter, then reset mid-stream
        @(posedge clk);
        #1;
        bus2.cfg_load = 1'b1; bus2.cfg_pattern = 8'h01; bus2.cfg_len = 4'd1;
        #3;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            bus2.cfg_load = 1'b0; bus2.in = 1'b1; bus2.in_valid = 1'b1;
            #3;
            check("t6_dec", 32'(bus2.dec), 32'd1);
            check("t6_cnt", 32'(bus2.match_cnt), CNT_EN ? 32'((i > 3) ? 3 : i) : 32'd0);
        end
        @(posedge clk);
        #4;
        check("t6_cnt_sat", 32'(bus2.match_cnt), CNT_EN ? 32'd3 : 32'd0);
        check("t6_dec_pre_rst", 32'(bus2.dec), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_dec", 32'(bus2.dec), 32'd0);
        check("t6_rst_cnt", 32'(bus2.match_cnt), 32'd0);
        check("t6_rst_configured", 32'(bus2.configured), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #3;
        check("t6_post_rst_dec", 32'(bus2.dec), 32'd0);
        check("t6_post_rst_configured", 32'(bus2.configured), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
